// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg : states, opcode field bounds and END opcode for fetch/decode
// Revision       : 1.0
// ============================================================================
package fetch_unit_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [5:0] OPC_END = 6'h3F;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_unit_if : program-memory, execute-side and status signals of fetch
// Revision      : 1.0
// ============================================================================
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   io_run;
  logic [PC_WIDTH-1:0]    io_pcAddress;
  logic [INSTR_WIDTH-1:0] io_instruction;
  logic                   io_stall;
  logic                   io_jump;
  logic [PC_WIDTH-1:0]    io_jumpTarget;
  logic [INSTR_WIDTH-1:0] io_instr;
  logic [5:0]             io_opcode;
  logic                   io_valid;
  logic                   io_busy;
  logic                   io_done;

  modport master (
    input  io_run, io_instruction, io_stall, io_jump, io_jumpTarget,
    output io_pcAddress, io_instr, io_opcode, io_valid, io_busy, io_done
  );

  modport slave (
    output io_run, io_instruction, io_stall, io_jump, io_jumpTarget,
    input  io_pcAddress, io_instr, io_opcode, io_valid, io_busy, io_done
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_program_counter.sv
`default_nettype none
// ============================================================================
// program_counter : PC register with load, wrapping increment and hold
// Revision        : 1.0
// ============================================================================
module program_counter #(
  parameter int PC_WIDTH = 16
) (
  input  wire logic                clock,
  input  wire logic                reset,
  input  wire logic                load,
  input  wire logic                inc,
  input  wire logic [PC_WIDTH-1:0] target,
  output logic      [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC, instruction register and fetch sequencer (one instr/3 clk)
// Revision   : 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int         PC_WIDTH    = 16,
  parameter int         INSTR_WIDTH = 32,
  parameter logic [5:0] END_OPCODE  = OPC_END
) (
  input  wire logic    clock,
  input  wire logic    reset,
  fetch_unit_if.master bus
);

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [INSTR_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]    pc;
  logic                   exec_go;
  logic                   is_end;
  logic                   pc_load;
  logic                   pc_inc;

  assign is_end  = (ir[OPCODE_MSB:OPCODE_LSB] == END_OPCODE);
  // Only an unstalled EXEC cycle retires the instruction and may move the PC.
  assign exec_go = (state == ST_EXEC) && !bus.io_stall;
  assign pc_load = exec_go && !is_end && bus.io_jump;
  assign pc_inc  = exec_go && !is_end && !bus.io_jump;

  program_counter #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc (
    .clock  (clock),
    .reset  (reset),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (bus.io_jumpTarget),
    .pc     (pc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.io_run) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!bus.io_stall) state_nxt = is_end ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_LATCH) ir <= bus.io_instruction;
    end
  end

  assign bus.io_pcAddress = pc;
  assign bus.io_instr     = ir;
  assign bus.io_opcode    = ir[OPCODE_MSB:OPCODE_LSB];
  assign bus.io_valid     = (state == ST_EXEC);
  assign bus.io_busy      = (state == ST_FETCH) || (state == ST_LATCH) || (state == ST_EXEC);
  assign bus.io_done      = (state == ST_HALT);

endmodule
`default_nettype wire
